// File: rtl/led_chaser_multimode.sv
// Multi-mode LED pattern generator: fill-from-MSB, fill-from-LSB, running dot, bounce dot,
// with prescaled stepping, one-shot completion, and optional LED_INVERT_EN active-low output.
module led_chaser_multimode #(
    parameter int N_LED    = 8,
    parameter int TICK_DIV = 1
) (
    input  logic             Clk,
    input  logic             RST,
    input  logic             SS,
    input  logic [1:0]       MODE,
    input  logic             ONESHOT,
    input  logic             RESTART,
    output logic [N_LED-1:0] LED,
    output logic             STEP,
    output logic             WRAP,
    output logic             DONE
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]    CNT_MAX  = CW'(TICK_DIV - 1);
    localparam logic [N_LED-1:0] MSB_ONLY = {1'b1, {(N_LED-1){1'b0}}};
    localparam logic [N_LED-1:0] LSB_ONLY = {{(N_LED-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        FILL_MSB = 2'd0,
        FILL_LSB = 2'd1,
        DOT      = 2'd2,
        BOUNCE   = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    mode_t            mode_q;
    mode_t            mode_in;
    dir_t             dir_q;
    dir_t             dir_nxt;
    logic [N_LED-1:0] pat_q;
    logic [N_LED-1:0] pat_nxt;
    logic [CW-1:0]    cnt_q;
    logic             seq_wrap;
    logic             tick;

    assign mode_in = mode_t'(MODE);
    assign tick    = SS && !DONE && (cnt_q == CNT_MAX);

    function automatic logic [N_LED-1:0] start_pat(input mode_t m);
        return (m == FILL_LSB) ? LSB_ONLY : MSB_ONLY;
    endfunction

    always_comb begin
        pat_nxt  = pat_q;
        dir_nxt  = dir_q;
        seq_wrap = 1'b0;
        case (mode_q)
            FILL_MSB: begin
                if (&pat_q) begin
                    pat_nxt  = MSB_ONLY;
                    seq_wrap = 1'b1;
                end else begin
                    pat_nxt = (pat_q >> 1) | MSB_ONLY;
                end
            end
            FILL_LSB: begin
                if (&pat_q) begin
                    pat_nxt  = LSB_ONLY;
                    seq_wrap = 1'b1;
                end else begin
                    pat_nxt = (pat_q << 1) | LSB_ONLY;
                end
            end
            DOT: begin
                if (pat_q == LSB_ONLY) begin
                    pat_nxt  = MSB_ONLY;
                    seq_wrap = 1'b1;
                end else begin
                    pat_nxt = pat_q >> 1;
                end
            end
            default: begin
                // Turn around at the LSB; arriving at the MSB closes the period
                // (also covers N_LED == 2, where the turn-around lands on the MSB).
                if ((dir_q == DIR_UP) || pat_q[0]) begin
                    pat_nxt = pat_q << 1;
                    dir_nxt = DIR_UP;
                end else begin
                    pat_nxt = pat_q >> 1;
                end
                if (pat_nxt[N_LED-1]) begin
                    seq_wrap = 1'b1;
                    dir_nxt  = DIR_DOWN;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or posedge RST) begin
        if (RST) begin
            pat_q  <= MSB_ONLY;
            mode_q <= FILL_MSB;
            cnt_q  <= '0;
            dir_q  <= DIR_DOWN;
            STEP   <= 1'b0;
            WRAP   <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            STEP <= 1'b0;
            WRAP <= 1'b0;
            if (RESTART) begin
                pat_q <= start_pat(mode_q);
                cnt_q <= '0;
                dir_q <= DIR_DOWN;
                DONE  <= 1'b0;
            end else if (mode_in != mode_q) begin
                mode_q <= mode_in;
                pat_q  <= start_pat(mode_in);
                cnt_q  <= '0;
                dir_q  <= DIR_DOWN;
                DONE   <= 1'b0;
            end else if (tick) begin
                cnt_q <= '0;
                WRAP  <= seq_wrap;
                // One-shot completion keeps the final pattern on display.
                if (seq_wrap && ONESHOT) begin
                    DONE <= 1'b1;
                end else begin
                    pat_q <= pat_nxt;
                    dir_q <= dir_nxt;
                    STEP  <= 1'b1;
                end
            end else if (SS && !DONE) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

`ifdef LED_INVERT_EN
    assign LED = ~pat_q;
`else
    assign LED = pat_q;
`endif

endmodule
